// File: rtl/vid_out_timing_fetch.sv
// vid_out_timing_fetch: raster timing generator that pulls show-ahead pixels from the frame-buffer read FIFO
module vid_out_timing_fetch #(
    parameter int H_ACTIVE    = 1920,
    parameter int H_FP        = 88,
    parameter int H_SYNC      = 44,
    parameter int H_BP        = 148,
    parameter int V_ACTIVE    = 1080,
    parameter int V_FP        = 4,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 36,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter int R_DATAWIDTH = 32
) (
    input  logic                   I_clk,
    input  logic                   I_rst,
    input  logic                   I_en,
    output logic                   O_R_FS,
    output logic                   O_R_rden,
    input  logic [R_DATAWIDTH-1:0] I_R_data,
    input  logic                   I_R_empty,
    output logic                   O_hs,
    output logic                   O_vs,
    output logic                   O_de,
    output logic [23:0]            O_rgb,
    output logic                   O_underflow,
    output logic [15:0]            O_uf_cnt,
    output logic                   O_running
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [HW-1:0] h_cnt, h_n;
    logic [VW-1:0] v_cnt, v_n;
    logic run, h_last, v_last, de_i, hs_i, vs_i, uf;
    logic unused_data;

    assign run    = state == RUN;
    assign h_last = h_cnt == H_LAST;
    assign v_last = v_cnt == V_LAST;
    assign de_i   = run && h_cnt < H_ACT && v_cnt < V_ACT;
    assign hs_i   = run && h_cnt >= HS_BEG && h_cnt < HS_END;
    assign vs_i   = run && v_cnt >= VS_BEG && v_cnt < VS_END;
    assign uf     = de_i && I_R_empty;
    assign O_R_FS    = vs_i;
    assign O_R_rden  = de_i && !I_R_empty;
    assign O_running = run;
    assign unused_data = ^I_R_data;

    // Starting in the front porch gives the buffer a full sync period to prefill before line 0.
    always_comb begin
        state_n = state;
        h_n     = h_cnt;
        v_n     = v_cnt;
        if (!run) begin
            state_n = I_en ? RUN : IDLE;
            h_n     = I_en ? '0 : h_cnt;
            v_n     = I_en ? V_ACT : v_cnt;
        end else begin
            h_n     = h_last ? '0 : h_cnt + 1'b1;
            v_n     = !h_last ? v_cnt : v_last ? '0 : v_cnt + 1'b1;
            state_n = (h_last && v_last && !I_en) ? IDLE : RUN;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_n;
            h_cnt <= h_n;
            v_cnt <= v_n;
        end
    end

    // Underflowed slots go out black; the raster keeps running.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_de        <= 1'b0;
            O_hs        <= ~HS_POL;
            O_vs        <= ~VS_POL;
            O_rgb       <= '0;
            O_underflow <= 1'b0;
            O_uf_cnt    <= '0;
        end else begin
            O_de        <= de_i;
            O_hs        <= hs_i ? HS_POL : ~HS_POL;
            O_vs        <= vs_i ? VS_POL : ~VS_POL;
            O_rgb       <= O_R_rden ? I_R_data[23:0] : 24'h0;
            O_underflow <= O_underflow || uf;
            O_uf_cnt    <= O_uf_cnt + 16'(uf && !(&O_uf_cnt));
        end
    end
endmodule
